// File: rtl/poke_arrange_multi.sv
// Card-hand rank remapper: LANES cards per cycle, optional odd-even sort.
// Optional feature macro: POKE_SORT_EN (sort the remapped hand ascending).
module poke_arrange_multi #(
  parameter int CARD_NUM = 17,
  parameter int CARD_W   = 8,
  parameter int RANK_W   = 4,
  parameter int LANES    = 1
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         receivepoke_done,
  input  logic [CARD_NUM*CARD_W-1:0]   receive_poke,
  output logic [CARD_NUM*CARD_W-1:0]   poke,
  output logic                         busy,
  output logic                         arrange_done
);

  localparam int HW = CARD_NUM * CARD_W;
  localparam int G  = (CARD_NUM + LANES - 1) / LANES;
  localparam int CW = $clog2(CARD_NUM + 1);

  localparam logic [RANK_W-1:0] TOP  = '1;
  localparam logic [RANK_W-1:0] TOP1 = TOP - RANK_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    MAP,
`ifdef POKE_SORT_EN
    SORT,
`endif
    OUT
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   work_q, work_d;
  logic [HW-1:0]   poke_q, poke_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [HW-1:0]   map_w;

  function automatic logic [CARD_W-1:0] remap(
    input logic [CARD_W-1:0] c
  );
    logic [CARD_W-1:0] r;
    r = c;
    if (c[CARD_W-1 -: RANK_W] == RANK_W'(2))
      r[CARD_W-1 -: RANK_W] = TOP;
    else if (c[CARD_W-1 -: RANK_W] == RANK_W'(1))
      r[CARD_W-1 -: RANK_W] = TOP1;
    return r;
  endfunction

  // Remap the cards of the current lane group; others pass through.
  always_comb begin
    map_w = work_q;
    for (int i = 0; i < CARD_NUM; i++) begin
      if (cnt_q == CW'(i / LANES))
        map_w[i*CARD_W +: CARD_W] =
          remap(work_q[i*CARD_W +: CARD_W]);
    end
  end

`ifdef POKE_SORT_EN
  logic [HW-1:0] sort_w;

  // One odd-even transposition phase; phase parity is cnt_q[0].
  always_comb begin
    sort_w = work_q;
    for (int i = 0; i < CARD_NUM - 1; i++) begin
      if (1'(i) == cnt_q[0]) begin
        if (work_q[i*CARD_W +: CARD_W] >
            work_q[(i+1)*CARD_W +: CARD_W]) begin
          sort_w[i*CARD_W +: CARD_W] =
            work_q[(i+1)*CARD_W +: CARD_W];
          sort_w[(i+1)*CARD_W +: CARD_W] =
            work_q[i*CARD_W +: CARD_W];
        end
      end
    end
  end
`endif

  // Next-state and output logic of the arrange FSM.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    poke_d  = poke_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (receivepoke_done) begin
          work_d  = receive_poke;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MAP;
        end
      end
      MAP: begin
        work_d = map_w;
        if (cnt_q == CW'(G - 1)) begin
          cnt_d = '0;
`ifdef POKE_SORT_EN
          state_d = SORT;
`else
          busy_d  = 1'b0;
          state_d = OUT;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef POKE_SORT_EN
      SORT: begin
        work_d = sort_w;
        if (cnt_q == CW'(CARD_NUM - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      OUT: begin
        poke_d  = work_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      poke_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      poke_q  <= poke_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign poke         = poke_q;
  assign busy         = busy_q;
  assign arrange_done = done_q;

endmodule
